// File: rtl/colour_stats_pkg.sv
// Shared types and constants for the colour frame statistics block.
// Holds the FSM state encoding, colour indices and a width helper.
package colour_stats_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int COL_R       = 0;
    localparam int COL_G       = 1;
    localparam int COL_B       = 2;
    localparam int NUM_COLOURS = 3;

    // Counter width able to index n values, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_classifier.sv
// Combinational RGB444 dominant-colour classifier producing a one-hot match.
// A component wins when it clears min_level and beats both others by margin.
module pixel_classifier
    import colour_stats_pkg::*;
(
    input  logic [11:0]            pixel,
    input  logic [3:0]             margin,
    input  logic [3:0]             min_level,
    output logic [NUM_COLOURS-1:0] match
);

    logic [3:0]             comp [NUM_COLOURS];
    logic [NUM_COLOURS-1:0] raw;

    assign comp[COL_R] = pixel[11:8];
    assign comp[COL_G] = pixel[7:4];
    assign comp[COL_B] = pixel[3:0];

    // The sum is widened to 5 bits so a large margin cannot wrap to a small value.
    function automatic logic dominates(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] m);
        return {1'b0, a} >= ({1'b0, b} + {1'b0, m});
    endfunction

    // NOTE: every always_comb output gets a default before any conditional update,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        raw = '0;
        for (int c = 0; c < NUM_COLOURS; c++) begin
            raw[c] = (comp[c] >= min_level)
                  && dominates(comp[c], comp[(c + 1) % NUM_COLOURS], margin)
                  && dominates(comp[c], comp[(c + 2) % NUM_COLOURS], margin);
        end
    end

    // Only a zero margin can produce a tie; R beats G beats B to keep it one-hot.
    assign match[COL_R] = raw[COL_R];
    assign match[COL_G] = raw[COL_G] & ~raw[COL_R];
    assign match[COL_B] = raw[COL_B] & ~raw[COL_R] & ~raw[COL_G];

endmodule

// File: rtl/colour_frame_stats.sv
// Per-frame dominant-colour statistics: per-colour and per-column-region pixel
// counts, peak region per colour, with frame framing checks on sop/eop.
module colour_frame_stats
    import colour_stats_pkg::*;
#(
    parameter int FRAME_W     = 320,
    parameter int FRAME_H     = 240,
    parameter int NUM_REGIONS = 3,
    parameter int COUNT_W     = 17
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [11:0]                            pixel,
    input  logic                                   valid,
    input  logic                                   ready,
    input  logic                                   sop,
    input  logic                                   eop,
    input  logic [3:0]                             margin,
    input  logic [3:0]                             min_level,
    output logic [3*COUNT_W-1:0]                   colour_count,
    output logic [3*NUM_REGIONS*COUNT_W-1:0]       region_count,
    output logic [3*((NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1)-1:0] peak_region,
    output logic                                   frame_valid,
    output logic                                   frame_err,
    output logic                                   busy
);

    localparam int TOTAL    = FRAME_W * FRAME_H;
    localparam int REGION_W = FRAME_W / NUM_REGIONS;
    localparam int PEAK_W   = width_of(NUM_REGIONS);
    localparam int COL_W    = width_of(FRAME_W);
    localparam int RCOL_W   = width_of(REGION_W);
    localparam int CNT_W    = width_of(TOTAL + 1);

    state_t              state;
    logic [COL_W-1:0]    col, cur_col, col_n;
    logic [RCOL_W-1:0]   rcol, cur_rcol, rcol_n;
    logic [PEAK_W-1:0]   region, cur_reg, reg_n;
    logic [CNT_W-1:0]    pix_cnt, cur_cnt;
    logic [COUNT_W-1:0]  cacc   [NUM_COLOURS];
    logic [COUNT_W-1:0]  cacc_n [NUM_COLOURS];
    logic [COUNT_W-1:0]  racc   [NUM_COLOURS][NUM_REGIONS];
    logic [COUNT_W-1:0]  racc_n [NUM_COLOURS][NUM_REGIONS];
    logic [NUM_COLOURS-1:0] match;

    logic [3*COUNT_W-1:0]             cc_n;
    logic [3*NUM_REGIONS*COUNT_W-1:0] rc_n;
    logic [3*PEAK_W-1:0]              pk_n;

    logic beat, restart, take, eop_ok, eop_bad, overflow, close, err_now;

    pixel_classifier u_classifier (
        .pixel     (pixel),
        .margin    (margin),
        .min_level (min_level),
        .match     (match)
    );

    assign beat    = valid && ready;
    assign restart = beat && sop;
    assign take    = beat && (sop || state == ACTIVE);

    // A sop beat is pixel 0 of a fresh frame, so positions start from zero.
    assign cur_col  = restart ? '0 : col;
    assign cur_rcol = restart ? '0 : rcol;
    assign cur_reg  = restart ? '0 : region;
    assign cur_cnt  = restart ? '0 : pix_cnt;

    assign eop_ok   = take && eop && (cur_cnt == CNT_W'(TOTAL - 1));
    assign eop_bad  = take && eop && !eop_ok;
    assign overflow = take && !eop && (cur_cnt == CNT_W'(TOTAL));
    assign close    = take && (eop || overflow);
    assign err_now  = (restart && state == ACTIVE) || eop_bad || overflow;
    assign busy     = (state == ACTIVE);

    always_comb begin
        col_n  = cur_col + 1'b1;
        rcol_n = cur_rcol + 1'b1;
        reg_n  = cur_reg;
        if (cur_col == COL_W'(FRAME_W - 1)) begin
            col_n  = '0;
            rcol_n = '0;
            reg_n  = '0;
        end else if (cur_rcol == RCOL_W'(REGION_W - 1)) begin
            rcol_n = '0;
            reg_n  = cur_reg + 1'b1;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_COLOURS; c++) begin
            cacc_n[c] = restart ? '0 : cacc[c];
            for (int r = 0; r < NUM_REGIONS; r++)
                racc_n[c][r] = restart ? '0 : racc[c][r];
            // Saturating increments keep an oversized frame from wrapping counts.
            if (take && match[c]) begin
                if (cacc_n[c] != '1)
                    cacc_n[c] = cacc_n[c] + 1'b1;
                if (racc_n[c][cur_reg] != '1)
                    racc_n[c][cur_reg] = racc_n[c][cur_reg] + 1'b1;
            end
        end
    end

    always_comb begin : pack_outputs
        logic [PEAK_W-1:0] best;
        cc_n = '0;
        rc_n = '0;
        pk_n = '0;
        for (int c = 0; c < NUM_COLOURS; c++) begin
            cc_n[c*COUNT_W +: COUNT_W] = cacc_n[c];
            best = '0;
            for (int r = 0; r < NUM_REGIONS; r++) begin
                rc_n[(c*NUM_REGIONS + r)*COUNT_W +: COUNT_W] = racc_n[c][r];
                // Strictly greater, so the lowest index keeps a tie.
                if (racc_n[c][r] > racc_n[c][best])
                    best = PEAK_W'(r);
            end
            pk_n[c*PEAK_W +: PEAK_W] = best;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            col          <= '0;
            rcol         <= '0;
            region       <= '0;
            pix_cnt      <= '0;
            // NOTE: the accumulator arrays are reset too, because an abort
            // mid-frame must leave every count cleared, not just the outputs.
            cacc         <= '{default: '0};
            racc         <= '{default: '{default: '0}};
            colour_count <= '0;
            region_count <= '0;
            peak_region  <= '0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= err_now;
            if (take) begin
                cacc <= cacc_n;
                racc <= racc_n;
                if (close) begin
                    state   <= IDLE;
                    col     <= '0;
                    rcol    <= '0;
                    region  <= '0;
                    pix_cnt <= '0;
                end else begin
                    state   <= ACTIVE;
                    col     <= col_n;
                    rcol    <= rcol_n;
                    region  <= reg_n;
                    pix_cnt <= cur_cnt + 1'b1;
                end
                if (eop_ok) begin
                    frame_valid  <= 1'b1;
                    colour_count <= cc_n;
                    region_count <= rc_n;
                    peak_region  <= pk_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_colour_frame_stats.sv
// Scoreboard bench for colour_frame_stats on a 6x2 frame with three regions.
// Stimulus pushes expected frame results; a monitor pops them on each pulse.
module tb_colour_frame_stats;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] pixel;
    logic        valid, ready, sop, eop;
    logic [3:0]  margin, min_level;
    logic [23:0] colour_count;
    logic [71:0] region_count;
    logic [5:0]  peak_region;
    logic        frame_valid, frame_err, busy;

    typedef struct {
        logic        fv;
        logic        fe;
        int          acc_edge;
        logic [23:0] cc;
        logic [71:0] rc;
        logic [5:0]  pk;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          edges = 0;
    int          last_edge = 0;
    logic [23:0] held_cc = '0;
    logic [71:0] held_rc = '0;
    logic [5:0]  held_pk = '0;

    localparam logic [71:0] PAT_A  = {6{12'hF00}};
    localparam logic [71:0] PAT_B  = {12'h0F0, 12'h0F0, 12'h888, 12'h888, 12'h888, 12'h888};
    localparam logic [71:0] PAT_D  = {12'h00F, 12'h00F, 12'hF00, 12'hF00, 12'h00F, 12'h00F};
    localparam logic [71:0] PAT_E  = {12'h0F0, 12'h0F0, 12'h00F, 12'hF00, 12'hF00, 12'h0F0};
    localparam logic [71:0] PAT_G1 = {12'h0C8, 12'h08C, 12'h700, 12'h800, 12'hB80, 12'hC80};
    localparam logic [71:0] PAT_G2 = {12'hF10, 12'hF00, 12'hF10, 12'hF00, 12'hF10, 12'hF00};

    colour_frame_stats #(
        .FRAME_W(6), .FRAME_H(2), .NUM_REGIONS(3), .COUNT_W(8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pixel        (pixel),
        .valid        (valid),
        .ready        (ready),
        .sop          (sop),
        .eop          (eop),
        .margin       (margin),
        .min_level    (min_level),
        .colour_count (colour_count),
        .region_count (region_count),
        .peak_region  (peak_region),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pack_cc(input int r, input int g, input int b);
        return {8'(b), 8'(g), 8'(r)};
    endfunction

    function automatic logic [71:0] pack_rc(input int r0, input int r1, input int r2,
                                            input int g0, input int g1, input int g2,
                                            input int b0, input int b1, input int b2);
        return {8'(b2), 8'(b1), 8'(b0), 8'(g2), 8'(g1), 8'(g0), 8'(r2), 8'(r1), 8'(r0)};
    endfunction

    function automatic logic [5:0] pack_pk(input int r, input int g, input int b);
        return {2'(b), 2'(g), 2'(r)};
    endfunction

    task automatic push_ok(input logic [23:0] cc, input logic [71:0] rc, input logic [5:0] pk);
        exp_t e;
        e.fv = 1'b1; e.fe = 1'b0; e.acc_edge = last_edge;
        e.cc = cc; e.rc = rc; e.pk = pk;
        q.push_back(e);
        held_cc = cc; held_rc = rc; held_pk = pk;
    endtask

    task automatic push_err();
        exp_t e;
        e.fv = 1'b0; e.fe = 1'b1; e.acc_edge = last_edge;
        e.cc = held_cc; e.rc = held_rc; e.pk = held_pk;
        q.push_back(e);
    endtask

    // Presents one beat for a single clock; last_edge records when it was sampled.
    task automatic send(input logic [11:0] p, input logic s, input logic e, input logic r);
        pixel = p; sop = s; eop = e; valid = 1'b1; ready = r;
        @(posedge clk);
        #1;
        last_edge = edges;
        valid = 1'b0; ready = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic frame(input logic [71:0] pat, input int n, input bit with_eop, input bit stall);
        logic [11:0] p;
        logic        s, e;
        for (int i = 0; i < n; i++) begin
            p = pat[(i % 6)*12 +: 12];
            s = (i == 0);
            e = with_eop && (i == n - 1);
            if (stall) send(p, s, e, 1'b0);
            send(p, s, e, 1'b1);
            if (i == 0) check("busy_active", {71'd0, busy}, 72'd1);
        end
        check("busy_idle_after_frame", {71'd0, busy}, 72'd0);
    endtask

    always @(negedge clk) begin
        if (reset_n && (frame_valid || frame_err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse frame_valid=%0b frame_err=%0b expected=none",
                         frame_valid, frame_err);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse_edge", 72'(edges), 72'(e.acc_edge));
                check("frame_valid", {71'd0, frame_valid}, {71'd0, e.fv});
                check("frame_err", {71'd0, frame_err}, {71'd0, e.fe});
                check("colour_count", {48'd0, colour_count}, {48'd0, e.cc});
                check("region_count", region_count, e.rc);
                check("peak_region", {66'd0, peak_region}, {66'd0, e.pk});
            end
        end
    end

    initial begin
        reset_n = 1'b0; pixel = '0; valid = 1'b0; ready = 1'b0;
        sop = 1'b0; eop = 1'b0; margin = 4'd4; min_level = 4'd8;
        #3;
        check("reset_colour_count", {48'd0, colour_count}, 72'd0);
        check("reset_region_count", region_count, 72'd0);
        check("reset_flags", {66'd0, peak_region, frame_valid, frame_err, busy}, 72'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // All red frame.
        frame(PAT_A, 12, 1'b1, 1'b0);
        push_ok(pack_cc(12, 0, 0), pack_rc(4, 4, 4, 0, 0, 0, 0, 0, 0), pack_pk(0, 0, 0));

        // Green only in the last region, grey counted nowhere.
        frame(PAT_B, 12, 1'b1, 1'b0);
        push_ok(pack_cc(0, 4, 0), pack_rc(0, 0, 0, 0, 0, 4, 0, 0, 0), pack_pk(0, 2, 0));

        // Short frame: eop on the tenth beat.
        frame(PAT_A, 10, 1'b1, 1'b0);
        push_err();

        // Sop again at beat 5: red prefix must be discarded.
        for (int i = 0; i < 5; i++) send(12'hF00, i == 0, 1'b0, 1'b1);
        send(PAT_D[11:0], 1'b1, 1'b0, 1'b1);
        push_err();
        for (int j = 1; j < 12; j++) send(PAT_D[(j % 6)*12 +: 12], 1'b0, j == 11, 1'b1);
        push_ok(pack_cc(4, 0, 8), pack_rc(0, 4, 0, 0, 0, 0, 4, 0, 4), pack_pk(1, 0, 0));

        // Pre-sop beats ignored, then a frame stalled by ready on alternate cycles.
        for (int i = 0; i < 3; i++) send(12'hF00, 1'b0, 1'b0, 1'b1);
        frame(PAT_E, 12, 1'b1, 1'b1);
        push_ok(pack_cc(4, 6, 2), pack_rc(2, 2, 0, 2, 0, 4, 0, 2, 0), pack_pk(0, 2, 1));

        // min_level and margin boundaries.
        frame(PAT_G1, 12, 1'b1, 1'b0);
        push_ok(pack_cc(4, 2, 2), pack_rc(2, 2, 0, 0, 0, 2, 0, 0, 2), pack_pk(0, 2, 2));

        // Margin 15: the other+margin sum must not wrap at 4 bits.
        margin = 4'hF; min_level = 4'h0;
        frame(PAT_G2, 12, 1'b1, 1'b0);
        push_ok(pack_cc(6, 0, 0), pack_rc(2, 2, 2, 0, 0, 0, 0, 0, 0), pack_pk(0, 0, 0));
        margin = 4'd4; min_level = 4'd8;

        // Thirteen beats without eop.
        frame(PAT_A, 13, 1'b0, 1'b0);
        push_err();

        // Sop and eop together in IDLE: a one-pixel frame is malformed here.
        send(12'hF00, 1'b1, 1'b1, 1'b1);
        push_err();
        check("busy_after_single", {71'd0, busy}, 72'd0);

        // Reset in the middle of a frame.
        for (int i = 0; i < 7; i++) send(PAT_E[(i % 6)*12 +: 12], i == 0, 1'b0, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midreset_colour_count", {48'd0, colour_count}, 72'd0);
        check("midreset_region_count", region_count, 72'd0);
        check("midreset_flags", {66'd0, peak_region, frame_valid, frame_err, busy}, 72'd0);
        held_cc = '0; held_rc = '0; held_pk = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        frame(PAT_A, 12, 1'b1, 1'b0);
        push_ok(pack_cc(12, 0, 0), pack_rc(4, 4, 4, 0, 0, 0, 0, 0, 0), pack_pk(0, 0, 0));

        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("queue_drained", 72'(q.size()), 72'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/colour_frame_stats.md
COLOUR_FRAME_STATS -- requirements
Module: colour_frame_stats

Interface
REQ-001 SHALL have parameter FRAME_W, default 320: pixels per line.
REQ-002 SHALL have parameter FRAME_H, default 240: lines per frame.
REQ-003 SHALL have parameter NUM_REGIONS, default 3: equal-width column regions; FRAME_W divisible by NUM_REGIONS.
REQ-004 SHALL have parameter COUNT_W, default 17: width of each counter.
REQ-005 SHALL have ports, in this order:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- pixel  in  12  RGB444 as {R[11:8], G[7:4], B[3:0]}.
- valid  in  1  pixel presented.
- ready  in  1  downstream sink accepts; a beat is accepted when valid && ready.
- sop  in  1  first pixel of frame.
- eop  in  1  last pixel of frame.
- margin  in  4  dominance margin.
- min_level  in  4  minimum dominant component.
- colour_count  out  3*COUNT_W  per-colour totals, R at LSBs.
- region_count  out  3*NUM_REGIONS*COUNT_W  per-colour, per-region totals, colour-major, region 0 at LSBs.
- peak_region  out  3*$clog2(NUM_REGIONS)  per colour, region with the highest count.
- frame_valid  out  1  one-cycle pulse when outputs update.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- busy  out  1  high in ACTIVE.

Function
REQ-006 SHALL classify each accepted pixel as colour c (R, G or B) when comp[c] >= min_level and comp[c] >= other+margin for both other components; the other+margin sum SHALL be computed at 5 bits; a pixel SHALL match at most one colour, and a pixel matching none SHALL be counted by no counter.
REQ-007 SHALL implement FSM IDLE -> ACTIVE -> IDLE; beats accepted in IDLE without sop SHALL be ignored.
REQ-008 In IDLE, an accepted beat with sop SHALL clear the accumulators, count that beat as pixel 0, and enter ACTIVE.
REQ-009 SHALL track the column with a counter wrapping at FRAME_W-1, and the region index with a counter that advances when the column reaches the next region boundary and resets to 0 on column wrap; no divider SHALL be used.
REQ-010 Accumulators SHALL saturate at 2^COUNT_W-1.
REQ-011 When a beat with eop is accepted in ACTIVE and the total beat count equals FRAME_W*FRAME_H: all outputs SHALL update, and frame_valid SHALL pulse, on the following cycle; the FSM SHALL return to IDLE.
REQ-012 When a beat with eop is accepted and the beat count differs from FRAME_W*FRAME_H: frame_err SHALL pulse, outputs SHALL hold their previous values, and the FSM SHALL return to IDLE.
REQ-013 When a beat with sop is accepted in ACTIVE: frame_err SHALL pulse, the accumulators SHALL restart with this beat as pixel 0, and the FSM SHALL stay in ACTIVE.
REQ-014 When the beat count would exceed FRAME_W*FRAME_H without eop: frame_err SHALL pulse and the FSM SHALL go to IDLE, discarding the frame.
REQ-015 When sop and eop are on the same beat: in IDLE it is a 1-pixel frame, valid only if FRAME_W*FRAME_H == 1, otherwise frame_err; in ACTIVE, REQ-013 SHALL apply and the frame SHALL then close per REQ-011/012.
REQ-016 peak_region SHALL be computed from the final region counts in the same update; on a tie, the lowest index SHALL win.
REQ-017 Beats with valid && !ready SHALL have no effect; ready SHALL be an input only and SHALL never be driven.

Reset
REQ-018 Asserting reset_n low SHALL immediately force: all outputs to 0, the FSM to IDLE, and all accumulators and counters to 0, including mid-frame.
REQ-019 After reset release, the first frame SHALL require sop.

Structure
REQ-020 Package colour_stats_pkg SHALL hold: the FSM state enum; colour index constants COL_R=0, COL_G=1, COL_B=2; NUM_COLOURS=3.
REQ-021 Classification SHALL be a combinational sub-module, pixel_classifier (pixel, margin, min_level -> one-hot 3-bit match).
REQ-022 The top level SHALL contain the FSM, the column/region counters, the accumulators, and the output registers.

Verification (FRAME_W=6, FRAME_H=2, NUM_REGIONS=3, COUNT_W=8)
REQ-023 12 beats of 0xF00, sop on the first and eop on the last, margin=4, min_level=8 -> colour_count R=12, G=B=0; region R counts 4,4,4; peak_region R=0; frame_valid one cycle after eop.
REQ-024 Frame with 0x0F0 in columns 4-5 and 0x888 elsewhere -> G=4, region G count = 4 in region 2, peak_region G=2; 0x888 pixels counted nowhere.
REQ-025 Eop on beat 10 -> frame_err pulse, no frame_valid, outputs unchanged from the previous frame.
REQ-026 Sop reasserted at beat 5, then 12 further beats with eop -> frame_err at beat 5, then frame_valid with counts from the restarted frame only.
REQ-027 ready low on alternate cycles while valid is held -> counts identical to the uninterrupted case; 3 pre-sop beats ignored.
REQ-028 reset_n asserted at beat 7 -> all outputs 0 immediately; the next full frame reports correctly.
